// File: rtl/expu_pkg.sv
// ---------------------------------------------------------------------------
// expu_pkg
// Shared definitions for the exponential-unit scheduler slice:
//   - fp_format_e     : floating-point format selector (fpnew encoding)
//   - fp_width / fp_exp_bits / fp_man_bits : format geometry
//   - rr_pick         : round-robin one-hot pick starting at a pointer
// No ports (package).
// ---------------------------------------------------------------------------
package expu_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    // Widest requester vector rr_pick can handle.
    localparam int unsigned RR_MAX = 32'd32;

    function automatic int unsigned fp_width(input fp_format_e fmt);
        case (fmt)
            FP32:    return 32'd32;
            FP64:    return 32'd64;
            FP16:    return 32'd16;
            FP8:     return 32'd8;
            FP16ALT: return 32'd16;
            default: return 32'd16;
        endcase
    endfunction

    function automatic int unsigned fp_exp_bits(input fp_format_e fmt);
        case (fmt)
            FP32:    return 32'd8;
            FP64:    return 32'd11;
            FP16:    return 32'd5;
            FP8:     return 32'd5;
            FP16ALT: return 32'd8;
            default: return 32'd8;
        endcase
    endfunction

    function automatic int unsigned fp_man_bits(input fp_format_e fmt);
        case (fmt)
            FP32:    return 32'd23;
            FP64:    return 32'd52;
            FP16:    return 32'd10;
            FP8:     return 32'd2;
            FP16ALT: return 32'd7;
            default: return 32'd7;
        endcase
    endfunction

    // Returns a one-hot vector selecting the first set bit of valid[n-1:0],
    // searching upward from ptr and wrapping modulo n. Zero if none set.
    function automatic logic [RR_MAX-1:0] rr_pick(
        input logic [RR_MAX-1:0] valid,
        input int unsigned       ptr,
        input int unsigned       n
    );
        logic [RR_MAX-1:0] grant;
        logic              found;
        int unsigned       idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            idx = ptr + k;
            if (idx >= n) begin
                idx = idx - n;
            end else begin
                idx = idx;
            end
            if ((k < n) && !found && valid[idx[4:0]]) begin
                grant[idx[4:0]] = 1'b1;
                found           = 1'b1;
            end else begin
                found = found;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/expu_result_fifo.sv
// ---------------------------------------------------------------------------
// expu_result_fifo
// First-word-fall-through FIFO of DEPTH entries of type T.
// Ports:
//   clk_i, rst_ni (async active-low), clear_i (sync flush)
//   push_i, data_i         : write side (no full check; caller guarantees room)
//   valid_o, ready_i, data_o : FWFT read side, pop on valid_o & ready_i
//   count_o                : number of stored entries
// data_o reads as zero while the FIFO is empty.
// ---------------------------------------------------------------------------
module expu_result_fifo #(
    parameter int unsigned DEPTH = 3,
    parameter type         T     = logic [7:0],
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  T                 data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output T                 data_o,
    output logic [CNT_W-1:0] count_o
);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign valid_o = (r_count != '0);
    assign w_pop   = valid_o & ready_i;
    assign count_o = r_count;

    // Head of FIFO, forced to zero when empty.
    always_comb begin
        data_o = '0;
        if (valid_o) begin
            data_o = r_mem[r_rd_ptr];
        end else begin
            data_o = '0;
        end
    end

    // Storage array; contents are only meaningful under r_count.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({push_i, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    expu_result_fifo_checker #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (push_i),
        .pop_i   (w_pop),
        .count_i (r_count)
    );

endmodule

// File: rtl/expu_result_fifo_checker.sv
// ---------------------------------------------------------------------------
// expu_result_fifo_checker
// Property checks for expu_result_fifo.
// Ports: clk_i, rst_ni, clear_i, push_i, pop_i, count_i (observed only).
// ---------------------------------------------------------------------------
module expu_result_fifo_checker #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CNT_W = 2
) (
    input logic             clk_i,
    input logic             rst_ni,
    input logic             clear_i,
    input logic             push_i,
    input logic             pop_i,
    input logic [CNT_W-1:0] count_i
);

    // A push without a simultaneous pop must never land on a full FIFO.
    a_no_overflow: assert property (
        @(posedge clk_i) disable iff (!rst_ni || clear_i)
        (push_i && !pop_i) |-> (count_i < CNT_W'(DEPTH))
    );

endmodule

// File: rtl/expu_scheduler.sv
// ---------------------------------------------------------------------------
// expu_scheduler
// Shares one expu_schraudolph datapath among N_REQ requesters.
// Ports:
//   clk_i, rst_ni (async active-low), clear_i (sync flush)
//   req_valid_i / req_op_i / req_ready_o : per-requester valid/ready input
//   dp_enable_o / dp_clear_o / dp_op_o   : drive the datapath input register
//   dp_mantissa_i / dp_exponent_i        : datapath result, valid 1 cycle after issue
//   res_valid_o / res_ready_i / res_id_o / res_data_o : ID-tagged result stream
//   busy_o : an op is in flight or results are buffered
// Grants are round-robin and gated so that every issued op is guaranteed a
// FIFO slot; the gate never looks at res_ready_i.
// ---------------------------------------------------------------------------
module expu_scheduler
    import expu_pkg::*;
#(
    parameter int unsigned  N_REQ         = 4,
    parameter fp_format_e   FPFORMAT      = FP16ALT,
    parameter int unsigned  DEPTH         = 3,
    localparam int unsigned WIDTH         = fp_width(FPFORMAT),
    localparam int unsigned EXPONENT_BITS = fp_exp_bits(FPFORMAT),
    localparam int unsigned MANTISSA_BITS = fp_man_bits(FPFORMAT),
    localparam int unsigned ID_W          = $clog2(N_REQ)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ-1:0][WIDTH-1:0] req_op_i,
    output logic [N_REQ-1:0]            req_ready_o,
    output logic                        dp_enable_o,
    output logic                        dp_clear_o,
    output logic [WIDTH-1:0]            dp_op_o,
    input  logic [MANTISSA_BITS-1:0]    dp_mantissa_i,
    input  logic [EXPONENT_BITS-1:0]    dp_exponent_i,
    output logic                        res_valid_o,
    input  logic                        res_ready_i,
    output logic [ID_W-1:0]             res_id_o,
    output logic [WIDTH-1:0]            res_data_o,
    output logic                        busy_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] data;
    } expu_res_t;

    logic             r_run;
    logic [ID_W-1:0]  r_rr_ptr;
    logic             r_inflight_vld;
    logic [ID_W-1:0]  r_inflight_id;

    logic             w_issue_ok;
    logic [N_REQ-1:0] w_pick;
    logic [N_REQ-1:0] w_grant;
    logic             w_grant_any;
    logic [ID_W-1:0]  w_grant_id;
    logic [WIDTH-1:0] w_grant_op;
    logic [ID_W-1:0]  w_rr_ptr_nxt;
    logic [CNT_W-1:0] w_fifo_count;
    logic             w_fifo_valid;
    expu_res_t        w_push_data;
    expu_res_t        w_head;

    // Issue gate: counting the in-flight op reserves its FIFO slot up front.
    always_comb begin
        w_issue_ok = 1'b0;
        if (r_run && !clear_i &&
            ((int'(w_fifo_count) + int'(r_inflight_vld)) < int'(DEPTH))) begin
            w_issue_ok = 1'b1;
        end else begin
            w_issue_ok = 1'b0;
        end
    end

    // Round-robin pick and gated grant.
    always_comb begin
        w_pick = N_REQ'(rr_pick(RR_MAX'(req_valid_i), 32'(r_rr_ptr), N_REQ));
        if (w_issue_ok) begin
            w_grant = w_pick;
        end else begin
            w_grant = '0;
        end
    end

    // One-hot grant to index and operand mux (OR-reduction, zero when idle).
    always_comb begin
        w_grant_id = '0;
        w_grant_op = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_grant_id = w_grant_id | (w_grant[i] ? ID_W'(i) : '0);
            w_grant_op = w_grant_op | (w_grant[i] ? req_op_i[i] : '0);
        end
        w_grant_any = |w_grant;
    end

    // Pointer moves to the requester after the one just granted.
    always_comb begin
        w_rr_ptr_nxt = '0;
        if (w_grant_id == ID_W'(N_REQ - 1)) begin
            w_rr_ptr_nxt = '0;
        end else begin
            w_rr_ptr_nxt = w_grant_id + ID_W'(1);
        end
    end

    // Run flag, arbitration pointer and in-flight tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_run          <= 1'b0;
            r_rr_ptr       <= '0;
            r_inflight_vld <= 1'b0;
            r_inflight_id  <= '0;
        end else begin
            r_run <= 1'b1;
            if (clear_i) begin
                r_rr_ptr       <= '0;
                r_inflight_vld <= 1'b0;
                r_inflight_id  <= '0;
            end else begin
                r_inflight_vld <= w_grant_any;
                r_inflight_id  <= w_grant_id;
                if (w_grant_any) begin
                    r_rr_ptr <= w_rr_ptr_nxt;
                end
            end
        end
    end

    // The datapath result is valid exactly one cycle after the issue.
    assign w_push_data.id   = r_inflight_id;
    assign w_push_data.data = {1'b0, dp_exponent_i, dp_mantissa_i};

    expu_result_fifo #(
        .DEPTH (DEPTH),
        .T     (expu_res_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (r_inflight_vld),
        .data_i  (w_push_data),
        .valid_o (w_fifo_valid),
        .ready_i (res_ready_i),
        .data_o  (w_head),
        .count_o (w_fifo_count)
    );

    assign req_ready_o = w_grant;
    assign dp_enable_o = w_grant_any;
    assign dp_clear_o  = clear_i;
    assign dp_op_o     = w_grant_op;
    assign res_valid_o = w_fifo_valid;
    assign res_id_o    = w_head.id;
    assign res_data_o  = w_head.data;
    assign busy_o      = r_inflight_vld | (w_fifo_count != '0);

endmodule

// File: tb/tb_expu_scheduler.sv
module tb_expu_scheduler;
    import expu_pkg::*;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic [3:0]       req_valid;
    logic [3:0][15:0] req_op;
    logic [3:0]       req_ready;
    logic             dp_enable;
    logic             dp_clear;
    logic [15:0]      dp_op;
    logic [6:0]       dp_man;
    logic [7:0]       dp_exp;
    logic             res_valid;
    logic             res_ready;
    logic [1:0]       res_id;
    logic [15:0]      res_data;
    logic             busy;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   remaining [4];
    exp_t exp_q [$];
    int   grant_log [$];
    int   id_log [$];
    int   g0;
    int   i0;

    logic [3:0]  s_ready;
    logic        s_res_valid;
    logic [1:0]  s_res_id;
    logic [15:0] s_res_data;
    logic        s_busy;
    logic        s_dp_en;
    logic        s_dp_clear;

    always #5 clk = ~clk;

    expu_scheduler #(
        .N_REQ    (4),
        .FPFORMAT (FP16ALT),
        .DEPTH    (3)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clear_i       (clear),
        .req_valid_i   (req_valid),
        .req_op_i      (req_op),
        .req_ready_o   (req_ready),
        .dp_enable_o   (dp_enable),
        .dp_clear_o    (dp_clear),
        .dp_op_o       (dp_op),
        .dp_mantissa_i (dp_man),
        .dp_exponent_i (dp_exp),
        .res_valid_o   (res_valid),
        .res_ready_i   (res_ready),
        .res_id_o      (res_id),
        .res_data_o    (res_data),
        .busy_o        (busy)
    );

    // Stand-in for the Schraudolph datapath: known reference points from the
    // rounding datapath, and an arbitrary but fixed mapping for anything else.
    function automatic logic [14:0] dp_model(input logic [15:0] op);
        case (op)
            16'h0000: return 15'h3F80;
            16'h3F80: return 15'h4039;
            16'h4300: return 15'h7F80;
            16'hC300: return 15'h0000;
            default:  return {op[7:0] ^ 8'hA5, op[14:8]};
        endcase
    endfunction

    logic [15:0] dp_r;
    logic [14:0] dp_res;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dp_r <= 16'h0000;
        else if (dp_clear) dp_r <= 16'h0000;
        else if (dp_enable) dp_r <= dp_op;
    end
    assign dp_res = dp_model(dp_r);
    assign dp_exp = dp_res[14:7];
    assign dp_man = dp_res[6:0];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample at negedge, score handshakes, then step the
    // requesters just after the rising edge.
    task automatic tick();
        logic [3:0] hs;
        exp_t       e;
        @(negedge clk);
        s_ready     = req_ready;
        s_res_valid = res_valid;
        s_res_id    = res_id;
        s_res_data  = res_data;
        s_busy      = busy;
        s_dp_en     = dp_enable;
        s_dp_clear  = dp_clear;
        hs = req_valid & req_ready;
        chk("grant_onehot", 32'($countones(req_ready) <= 1), 32'h1);
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                e.id   = 2'(i);
                e.data = {1'b0, dp_model(req_op[i])};
                exp_q.push_back(e);
                grant_log.push_back(i);
            end
        end
        if (res_valid && res_ready) begin
            id_log.push_back(int'(res_id));
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_result", 32'(exp_q.size()), 32'h1);
            end else begin
                e = exp_q.pop_front();
                chk("res_id", 32'(res_id), 32'(e.id));
                chk("res_data", 32'(res_data), 32'(e.data));
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                if (remaining[i] > 1) begin
                    remaining[i]--;
                    req_op[i] = 16'($urandom);
                end else begin
                    remaining[i] = 0;
                    req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic set_all(input int n);
        for (int i = 0; i < 4; i++) begin
            remaining[i] = n;
            req_op[i]    = 16'($urandom);
        end
        req_valid = (n > 0) ? 4'hF : 4'h0;
    endtask

    initial begin
        req_valid = 4'h0;
        req_op    = '0;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) remaining[i] = 0;

        // Reset state
        tick();
        tick();
        chk("rst_res_valid", 32'(s_res_valid), 32'h0);
        chk("rst_res_id", 32'(s_res_id), 32'h0);
        chk("rst_res_data", 32'(s_res_data), 32'h0);
        chk("rst_busy", 32'(s_busy), 32'h0);
        chk("rst_ready", 32'(s_ready), 32'h0);
        chk("rst_dp_enable", 32'(s_dp_en), 32'h0);

        // 1. Single op: zero operand, granted in cycle 2 after reset
        req_valid[0] = 1'b1;
        req_op[0]    = 16'h0000;
        remaining[0] = 1;
        rst_n = 1'b1;
        tick();
        chk("t1_no_grant_before_run", 32'(s_ready), 32'h0);
        tick();
        chk("t1_ready0", 32'(s_ready), 32'h1);
        chk("t1_dp_enable", 32'(s_dp_en), 32'h1);
        tick();
        chk("t1_not_early", 32'(s_res_valid), 32'h0);
        tick();
        chk("t1_res_valid", 32'(s_res_valid), 32'h1);
        chk("t1_res_id", 32'(s_res_id), 32'h0);
        chk("t1_res_data", 32'(s_res_data), 32'h3F80);

        // 2. Approximation of exp(1)
        req_valid[1] = 1'b1;
        req_op[1]    = 16'h3F80;
        remaining[1] = 1;
        tick();
        chk("t2_ready1", 32'(s_ready), 32'h2);
        tick();
        tick();
        chk("t2_res_valid", 32'(s_res_valid), 32'h1);
        chk("t2_res_id", 32'(s_res_id), 32'h1);
        chk("t2_res_data", 32'(s_res_data), 32'h4039);

        // 3. Round-robin, starting from a cleared pointer
        clear = 1'b1;
        tick();
        chk("t3_dp_clear", 32'(s_dp_clear), 32'h1);
        chk("t3_clear_no_grant", 32'(s_ready), 32'h0);
        clear = 1'b0;
        set_all(100);
        g0 = grant_log.size();
        i0 = id_log.size();
        repeat (8) tick();
        chk("t3_grant_count", 32'(grant_log.size() - g0), 32'd8);
        for (int k = 0; k < 6; k++) chk("t3_grant_order", 32'(grant_log[g0 + k]), 32'(k % 4));
        chk("t3_result_count", 32'(id_log.size() - i0), 32'd6);
        for (int k = 0; k < 6; k++) chk("t3_res_id_order", 32'(id_log[i0 + k]), 32'(k % 4));
        set_all(0);
        repeat (3) tick();
        chk("t3_drained", 32'(exp_q.size()), 32'h0);
        chk("t3_idle", 32'(s_busy), 32'h0);

        // 4. Backpressure
        res_ready    = 1'b0;
        req_valid[2] = 1'b1;
        req_op[2]    = 16'($urandom);
        remaining[2] = 100;
        g0 = grant_log.size();
        repeat (6) tick();
        chk("t4_grants", 32'(grant_log.size() - g0), 32'd3);
        chk("t4_ready_held", 32'(s_ready), 32'h0);
        chk("t4_busy", 32'(s_busy), 32'h1);
        res_ready = 1'b1;
        tick();
        chk("t4_release_no_grant", 32'(s_ready), 32'h0);
        chk("t4_release_valid", 32'(s_res_valid), 32'h1);
        tick();
        chk("t4_resume", 32'(s_ready), 32'h4);
        req_valid[2] = 1'b0;
        remaining[2] = 0;
        repeat (4) tick();
        chk("t4_drained", 32'(exp_q.size()), 32'h0);

        // 5. Overflow and underflow
        req_valid[3] = 1'b1;
        req_op[3]    = 16'h4300;
        remaining[3] = 1;
        tick();
        chk("t5_ready3_a", 32'(s_ready), 32'h8);
        req_valid[3] = 1'b1;
        req_op[3]    = 16'hC300;
        remaining[3] = 1;
        tick();
        chk("t5_ready3_b", 32'(s_ready), 32'h8);
        tick();
        chk("t5_inf_valid", 32'(s_res_valid), 32'h1);
        chk("t5_inf_data", 32'(s_res_data), 32'h7F80);
        tick();
        chk("t5_zero_valid", 32'(s_res_valid), 32'h1);
        chk("t5_zero_data", 32'(s_res_data), 32'h0000);
        tick();
        chk("t5_drained", 32'(exp_q.size()), 32'h0);

        // 6. Clear with one op in flight and two buffered
        res_ready    = 1'b0;
        req_valid[2] = 1'b1;
        req_op[2]    = 16'($urandom);
        remaining[2] = 100;
        g0 = grant_log.size();
        repeat (3) tick();
        chk("t6_grants", 32'(grant_log.size() - g0), 32'd3);
        clear = 1'b1;
        tick();
        chk("t6_clear_no_grant", 32'(s_ready), 32'h0);
        chk("t6_busy_before", 32'(s_busy), 32'h1);
        chk("t6_dp_clear", 32'(s_dp_clear), 32'h1);
        clear        = 1'b0;
        exp_q.delete();
        req_valid    = 4'b1001;
        req_op[0]    = 16'($urandom);
        req_op[3]    = 16'($urandom);
        remaining[0] = 1;
        remaining[2] = 0;
        remaining[3] = 1;
        res_ready    = 1'b1;
        tick();
        chk("t6_res_valid_cleared", 32'(s_res_valid), 32'h0);
        chk("t6_busy_cleared", 32'(s_busy), 32'h0);
        chk("t6_grant_req0", 32'(s_ready), 32'h1);
        repeat (5) tick();
        chk("t6_drained", 32'(exp_q.size()), 32'h0);

        // 7. Asynchronous reset mid-stream
        set_all(100);
        repeat (5) tick();
        chk("t7_pre_valid", 32'(s_res_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t7_async_res_valid", 32'(res_valid), 32'h0);
        chk("t7_async_busy", 32'(busy), 32'h0);
        chk("t7_async_ready", 32'(req_ready), 32'h0);
        exp_q.delete();
        tick();
        chk("t7_in_reset_ready", 32'(s_ready), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("t7_ready_before_run", 32'(s_ready), 32'h0);
        tick();
        chk("t7_ready_after_run", 32'(s_ready), 32'h1);
        set_all(0);
        repeat (4) tick();
        chk("t7_drained", 32'(exp_q.size()), 32'h0);
        chk("t7_idle", 32'(s_busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
